sram_march_bist: RTL and testbench

- Parametrised March C- BIST engine that drives the BIST port of a single-port SRAM macro with bit-mask (BIST_EN/MEN/WEN/REN/ADDR/DIN/BM) and checks read data on DOUT.
- Sits beside each SRAM macro instance. It owns the macro's BIST port while a test runs and releases it (BIST_EN low) when idle.
- Generalised over data width, address width, word count, read latency and data background.
- Reports pass/fail, the first failing address and a saturating failure count.

---
 rtl/sram_march_bist.sv | 253 +++++++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_bist
// Brief    : March C- BIST engine driving the BIST port of a single-port SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module sram_march_bist #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int NUM_WORDS = 512,
    parameter int READ_LAT  = 1,
    parameter int CHECKER   = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              bist_en_o,
    output logic              bist_men_o,
    output logic              bist_wen_o,
    output logic              bist_ren_o,
    output logic [ADDR_W-1:0] bist_addr_o,
    output logic [DATA_W-1:0] bist_din_o,
    output logic [DATA_W-1:0] bist_bm_o,
    input  logic [DATA_W-1:0] bist_dout_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [CNT_W-1:0]  fail_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_M0    = 3'd1,
        S_M1    = 3'd2,
        S_M2    = 3'd3,
        S_M3    = 3'd4,
        S_M4    = 3'd5,
        S_M5    = 3'd6,
        S_DRAIN = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0]    c_last_addr  = ADDR_W'(NUM_WORDS - 1);
    localparam int                   c_drain_w    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(READ_LAT - 1);

    logic [DATA_W-1:0] w_bg;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bg
            assign w_bg[gi] = (CHECKER != 0) && (gi % 2 == 1);
        end
    endgenerate

    state_t                r_state, w_state_n;
    logic [ADDR_W-1:0]     r_addr, w_addr_n;
    logic                  r_phase, w_phase_n;
    logic [c_drain_w-1:0]  r_drain, w_drain_n;
    logic                  w_men, w_wen, w_ren, w_push;
    logic [DATA_W-1:0]     w_din;
    logic                  w_active, w_up, w_last, w_flush, w_cmp_fail;
    logic [ADDR_W-1:0]     w_step;
    logic [DATA_W-1:0]     w_rd_val, w_wr_val;

    logic                  r_done, r_fail;
    logic [ADDR_W-1:0]     r_fail_addr;
    logic [CNT_W-1:0]      r_fail_cnt;

    logic                  r_pv [READ_LAT];
    logic [ADDR_W-1:0]     r_pa [READ_LAT];
    logic [DATA_W-1:0]     r_pe [READ_LAT];

    assign w_active = (r_state != S_IDLE);
    assign w_up     = (r_state != S_M3) && (r_state != S_M4);
    assign w_last   = w_up ? (r_addr == c_last_addr) : (r_addr == '0);
    assign w_step   = w_up ? (r_addr + 1'b1) : (r_addr - 1'b1);
    assign w_rd_val = ((r_state == S_M2) || (r_state == S_M4)) ? ~w_bg : w_bg;
    assign w_wr_val = ((r_state == S_M1) || (r_state == S_M3)) ? ~w_bg : w_bg;
    assign w_flush  = abort_i && w_active;

    always_comb begin
        w_state_n = r_state;
        w_addr_n  = r_addr;
        w_phase_n = r_phase;
        w_drain_n = r_drain;
        w_men     = 1'b0;
        w_wen     = 1'b0;
        w_ren     = 1'b0;
        w_din     = '0;
        w_push    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_n = S_M0;
                    w_addr_n  = '0;
                    w_phase_n = 1'b0;
                end
            end
            S_M0: begin
                w_men = 1'b1;
                w_wen = 1'b1;
                w_din = w_wr_val;
                if (w_last) begin
                    w_state_n = S_M1;
                    w_addr_n  = '0;
                end else begin
                    w_addr_n = w_step;
                end
            end
            S_M1, S_M2, S_M3, S_M4: begin
                w_men = 1'b1;
                if (!r_phase) begin
                    w_ren     = 1'b1;
                    w_push    = 1'b1;
                    w_phase_n = 1'b1;
                end else begin
                    w_wen     = 1'b1;
                    w_din     = w_wr_val;
                    w_phase_n = 1'b0;
                    if (w_last) begin
                        // Next element starts at the end matching its direction
                        case (r_state)
                            S_M1: begin
                                w_state_n = S_M2;
                                w_addr_n  = '0;
                            end
                            S_M2: begin
                                w_state_n = S_M3;
                                w_addr_n  = c_last_addr;
                            end
                            S_M3: begin
                                w_state_n = S_M4;
                                w_addr_n  = c_last_addr;
                            end
                            default: begin
                                w_state_n = S_M5;
                                w_addr_n  = '0;
                            end
                        endcase
                    end else begin
                        w_addr_n = w_step;
                    end
                end
            end
            S_M5: begin
                w_men  = 1'b1;
                w_ren  = 1'b1;
                w_push = 1'b1;
                if (w_last) begin
                    w_state_n = S_DRAIN;
                    w_addr_n  = '0;
                    w_drain_n = '0;
                end else begin
                    w_addr_n = w_step;
                end
            end
            S_DRAIN: begin
                if (r_drain == c_drain_last) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_drain_n = r_drain + 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_flush) begin
            w_state_n = S_IDLE;
            w_addr_n  = '0;
            w_phase_n = 1'b0;
            w_drain_n = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_phase <= 1'b0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_n;
            r_addr  <= w_addr_n;
            r_phase <= w_phase_n;
            r_drain <= w_drain_n;
        end
    end

    // Read tracking: slot READ_LAT-1 lines up with the data on bist_dout_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= '0;
                r_pe[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_push && !w_flush;
            r_pa[0] <= r_addr;
            r_pe[0] <= w_rd_val;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pv[i] <= r_pv[i-1] && !w_flush;
                r_pa[i] <= r_pa[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end

    assign w_cmp_fail = r_pv[READ_LAT-1] && (bist_dout_i != r_pe[READ_LAT-1]) && !w_flush;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_cnt  <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_cnt  <= '0;
        end else begin
            if ((r_state == S_DRAIN) && (r_drain == c_drain_last) && !abort_i) begin
                r_done <= 1'b1;
            end
            if (w_cmp_fail) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= r_pa[READ_LAT-1];
                end
                if (r_fail_cnt != {CNT_W{1'b1}}) begin
                    r_fail_cnt <= r_fail_cnt + 1'b1;
                end
            end
        end
    end

    assign bist_en_o   = w_active;
    assign busy_o      = w_active;
    assign bist_men_o  = w_men;
    assign bist_wen_o  = w_wen;
    assign bist_ren_o  = w_ren;
    assign bist_addr_o = r_addr;
    assign bist_din_o  = w_din;
    assign bist_bm_o   = {DATA_W{w_active}};
    assign done_o      = r_done;
    assign fail_o      = r_fail;
    assign fail_addr_o = r_fail_addr;
    assign fail_cnt_o  = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_march_bist
// Brief    : Directed bench for sram_march_bist with behavioural SRAM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_march_bist;

    logic clk;
    logic rst;
    logic start_v [3];
    logic abort_v [3];
    logic stuck_en;
    int   sel;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        a_en, a_men, a_wen, a_ren, a_busy, a_done, a_fail;
    logic [8:0]  a_addr, a_faddr;
    logic [31:0] a_din, a_bm, a_dout;
    logic [15:0] a_fcnt;

    logic        b_en, b_men, b_wen, b_ren, b_busy, b_done, b_fail;
    logic [2:0]  b_addr, b_faddr;
    logic [7:0]  b_din, b_bm, b_dout, b_p0;
    logic [15:0] b_fcnt;

    logic        c_en, c_men, c_wen, c_ren, c_busy, c_done, c_fail;
    logic [3:0]  c_addr, c_faddr;
    logic [7:0]  c_din, c_bm, c_dout;
    logic [15:0] c_fcnt;

    logic [31:0] mem_a [512];
    logic [7:0]  mem_b [8];
    logic [7:0]  mem_c [16];

    sram_march_bist #(.DATA_W(32), .ADDR_W(9), .NUM_WORDS(16), .READ_LAT(1), .CHECKER(0), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[0]), .abort_i(abort_v[0]),
        .bist_en_o(a_en), .bist_men_o(a_men), .bist_wen_o(a_wen), .bist_ren_o(a_ren),
        .bist_addr_o(a_addr), .bist_din_o(a_din), .bist_bm_o(a_bm), .bist_dout_i(a_dout),
        .busy_o(a_busy), .done_o(a_done), .fail_o(a_fail), .fail_addr_o(a_faddr), .fail_cnt_o(a_fcnt)
    );

    sram_march_bist #(.DATA_W(8), .ADDR_W(3), .NUM_WORDS(8), .READ_LAT(2), .CHECKER(0), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[1]), .abort_i(abort_v[1]),
        .bist_en_o(b_en), .bist_men_o(b_men), .bist_wen_o(b_wen), .bist_ren_o(b_ren),
        .bist_addr_o(b_addr), .bist_din_o(b_din), .bist_bm_o(b_bm), .bist_dout_i(b_dout),
        .busy_o(b_busy), .done_o(b_done), .fail_o(b_fail), .fail_addr_o(b_faddr), .fail_cnt_o(b_fcnt)
    );

    sram_march_bist #(.DATA_W(8), .ADDR_W(4), .NUM_WORDS(12), .READ_LAT(1), .CHECKER(1), .CNT_W(16)) u_c (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[2]), .abort_i(abort_v[2]),
        .bist_en_o(c_en), .bist_men_o(c_men), .bist_wen_o(c_wen), .bist_ren_o(c_ren),
        .bist_addr_o(c_addr), .bist_din_o(c_din), .bist_bm_o(c_bm), .bist_dout_i(c_dout),
        .busy_o(c_busy), .done_o(c_done), .fail_o(c_fail), .fail_addr_o(c_faddr), .fail_cnt_o(c_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro A: 1-cycle read, optional bit 3 stuck-at-1 at address 5
    always @(posedge clk) begin
        if (a_men && a_wen) mem_a[a_addr] <= a_din;
        if (a_men && a_ren) a_dout <= (stuck_en && a_addr == 9'd5) ? (mem_a[a_addr] | 32'h8) : mem_a[a_addr];
    end

    // Macro B: 2-cycle read, write to address 2 flips bit 0 of address 1
    always @(posedge clk) begin
        if (b_men && b_wen) begin
            mem_b[b_addr] <= b_din;
            if (b_addr == 3'd2) mem_b[1] <= mem_b[1] ^ 8'h01;
        end
        if (b_men && b_ren) b_p0 <= mem_b[b_addr];
        b_dout <= b_p0;
    end

    always @(posedge clk) begin
        if (c_men && c_wen) mem_c[c_addr] <= c_din;
        if (c_men && c_ren) c_dout <= mem_c[c_addr];
    end

    // Packed op view: {en, men, wen, ren, addr[15:0], din[31:0], bm_ok}
    logic [52:0] obs_op;
    logic        obs_busy, obs_done, obs_fail;
    logic [15:0] obs_faddr, obs_fcnt;
    logic [52:0] idle_op;

    assign idle_op = 53'd1;

    always_comb begin
        obs_op    = '0;
        obs_busy  = 1'b0;
        obs_done  = 1'b0;
        obs_fail  = 1'b0;
        obs_faddr = '0;
        obs_fcnt  = '0;
        case (sel)
            0: begin
                obs_op    = {a_en, a_men, a_wen, a_ren, 16'(a_addr), a_din, a_bm == (a_en ? 32'hFFFF_FFFF : 32'h0)};
                obs_busy  = a_busy; obs_done = a_done; obs_fail = a_fail;
                obs_faddr = 16'(a_faddr); obs_fcnt = a_fcnt;
            end
            1: begin
                obs_op    = {b_en, b_men, b_wen, b_ren, 16'(b_addr), 32'(b_din), b_bm == (b_en ? 8'hFF : 8'h00)};
                obs_busy  = b_busy; obs_done = b_done; obs_fail = b_fail;
                obs_faddr = 16'(b_faddr); obs_fcnt = b_fcnt;
            end
            default: begin
                obs_op    = {c_en, c_men, c_wen, c_ren, 16'(c_addr), 32'(c_din), c_bm == (c_en ? 8'hFF : 8'h00)};
                obs_busy  = c_busy; obs_done = c_done; obs_fail = c_fail;
                obs_faddr = 16'(c_faddr); obs_fcnt = c_fcnt;
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hand-written March C- op list: M0 w0 | M1..M4 (r,w) pairs | M5 r0
    function automatic logic [52:0] exp_op(input int n, input logic [31:0] bg, input logic [31:0] mask, input int idx);
        int          k, e, j, a;
        logic        wr;
        logic [31:0] d;
        if (idx < n) begin
            wr = 1'b1; a = idx; d = bg;
        end else if (idx < 9 * n) begin
            k  = idx - n;
            e  = k / (2 * n);
            j  = k % (2 * n);
            a  = j / 2;
            if (e >= 2) a = n - 1 - a;
            wr = (j % 2 == 1);
            d  = (e % 2 == 0) ? (~bg & mask) : bg;
        end else begin
            wr = 1'b0; a = idx - 9 * n; d = 32'h0;
        end
        if (!wr) d = 32'h0;
        return {1'b1, 1'b1, wr, !wr, 16'(a), d, 1'b1};
    endfunction

    task automatic run_trace(input int n, input logic [31:0] bg, input logic [31:0] mask, input int lat,
                             input int ignore_at, input int abort_at, input int rst_at,
                             input logic exp_fail, input int exp_faddr, input int exp_fcnt);
        @(posedge clk); #1 start_v[sel] = 1'b1;
        @(posedge clk); #1 start_v[sel] = 1'b0;
        for (int i = 0; i < 10 * n; i++) begin
            @(negedge clk);
            check_eq($sformatf("op%0d", i), obs_op, exp_op(n, bg, mask, i));
            if (i == 0) begin
                check_eq("start_status", {obs_busy, obs_done, obs_fail, obs_fcnt}, {1'b1, 1'b0, 1'b0, 16'h0});
            end
            if (i == ignore_at)     start_v[sel] = 1'b1;
            if (i == ignore_at + 1) start_v[sel] = 1'b0;
            if (i == abort_at) begin
                abort_v[sel] = 1'b1;
                @(posedge clk); #1 abort_v[sel] = 1'b0;
                @(negedge clk);
                check_eq("abort_ctl", {obs_op[52:49], obs_op[0], obs_busy, obs_done}, 7'b0000100);
                check_eq("abort_fail", {obs_fail, obs_faddr, obs_fcnt}, {exp_fail, 16'(exp_faddr), 16'(exp_fcnt)});
                return;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                check_eq("rst_op", obs_op, idle_op);
                check_eq("rst_status", {obs_busy, obs_done, obs_fail, obs_faddr, obs_fcnt}, 35'h0);
                @(negedge clk) rst = 1'b0;
                return;
            end
        end
        for (int d = 0; d < lat; d++) begin
            @(negedge clk);
            check_eq($sformatf("drain%0d", d), {obs_op[52:49], obs_busy, obs_done}, 6'b100010);
        end
        @(negedge clk);
        check_eq("end_ctl", {obs_op[52:49], obs_busy, obs_done}, 6'b000001);
        check_eq("end_fail", {obs_fail, obs_faddr, obs_fcnt}, {exp_fail, 16'(exp_faddr), 16'(exp_fcnt)});
    endtask

    initial begin
        rst      = 1'b1;
        sel      = 0;
        stuck_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_op", obs_op, idle_op);
        check_eq("reset_status", {obs_busy, obs_done, obs_fail, obs_faddr, obs_fcnt}, 35'h0);
        rst = 1'b0;

        // Clean run with an ignored start pulse mid-M1
        run_trace(16, 32'h0, 32'hFFFF_FFFF, 1, 40, -1, -1, 1'b0, 0, 0);
        // Stuck-at: r0 in M1, M3, M5 of address 5 mismatch
        stuck_en = 1'b1;
        run_trace(16, 32'h0, 32'hFFFF_FFFF, 1, -1, -1, -1, 1'b1, 5, 3);
        // Abort during M2: only the M1 mismatch has been counted
        run_trace(16, 32'h0, 32'hFFFF_FFFF, 1, -1, 53, -1, 1'b1, 5, 1);
        stuck_en = 1'b0;
        run_trace(16, 32'h0, 32'hFFFF_FFFF, 1, -1, -1, -1, 1'b0, 0, 0);
        // Asynchronous reset during M3 after a fail has been flagged
        stuck_en = 1'b1;
        run_trace(16, 32'h0, 32'hFFFF_FFFF, 1, -1, -1, 83, 1'b0, 0, 0);
        stuck_en = 1'b0;
        run_trace(16, 32'h0, 32'hFFFF_FFFF, 1, -1, -1, -1, 1'b0, 0, 0);

        // Coupling fault, 2-cycle read latency
        sel = 1;
        run_trace(8, 32'h0, 32'hFF, 2, -1, -1, -1, 1'b1, 1, 3);

        // Checkerboard background on a non-power-of-two depth
        sel = 2;
        run_trace(12, 32'hAA, 32'hFF, 1, -1, -1, -1, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
